// File: rtl/load_use_hazard_unit.sv
// ID-stage load-use hazard controller: bubbles ID/EX, holds IF/ID and PC, flushes IF/ID on taken branches.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module load_use_hazard_unit #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             ex_MemRead_i,
  input  logic [4:0]       ex_rd_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_useRs2_i,
  input  logic             branch_taken_i,
  output logic             NoOp_o,
  output logic             Stall_o,
  output logic             PCWrite_o,
  output logic             Flush_o,
  output logic [CNT_W-1:0] hazard_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  // The hazard cycle itself is the first bubble, so STALL covers the rest.
  localparam logic [2:0] RELOAD = 3'(STALL_CYCLES - 1);

  logic [0:0] state_q;
  logic [0:0] state_d;
  logic [2:0] cnt_q;
  logic [2:0] cnt_d;
  logic       hazard;

  assign hazard = ex_MemRead_i && (ex_rd_i != 5'd0)
                  && ((ex_rd_i == id_rs1_i) || (id_useRs2_i && (ex_rd_i == id_rs2_i)));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    NoOp_o    = 1'b0;
    Stall_o   = 1'b0;
    PCWrite_o = 1'b0;
    Flush_o   = 1'b0;

    if (rst_i) begin
      PCWrite_o = 1'b1;
    end else if (!start_i) begin
      // Pipeline frozen: state, count and all enables held off.
    end else if (state_q == STALL) begin
      NoOp_o  = 1'b1;
      Stall_o = 1'b1;
      if (cnt_q > 3'd1) begin
        cnt_d = cnt_q - 3'd1;
      end else begin
        cnt_d   = 3'd0;
        state_d = IDLE;
      end
    end else if (hazard) begin
      // Stall beats a taken branch: its operands are not valid yet, so it is re-evaluated later.
      NoOp_o  = 1'b1;
      Stall_o = 1'b1;
      if (STALL_CYCLES > 1) begin
        state_d = STALL;
        cnt_d   = RELOAD;
      end
    end else begin
      PCWrite_o = 1'b1;
      Flush_o   = branch_taken_i;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic             hazard_event;
  logic [CNT_W-1:0] hazard_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_q;

  assign hazard_event = !rst_i && start_i && (state_q == IDLE) && hazard;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hazard_cnt_q <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (hazard_event && (hazard_cnt_q != '1)) begin
        hazard_cnt_q <= hazard_cnt_q + CNT_W'(1);
      end
      if (NoOp_o && (bubble_cnt_q != '1)) begin
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  assign hazard_cnt_o = hazard_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign hazard_cnt_o = '0;
  assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Self-checking bench: three instances (STALL_CYCLES 1, 3, 4; one with 3-bit counters) checked every
// cycle against a bubble-budget model, plus directed literal checks.
module tb_load_use_hazard_unit;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b1;
  logic       mr = 1'b0;
  logic [4:0] rd = 5'd0;
  logic [4:0] rs1 = 5'd0;
  logic [4:0] rs2 = 5'd0;
  logic       use2 = 1'b0;
  logic       br = 1'b0;

  always #5 clk = ~clk;

  logic        nop [3];
  logic        stl [3];
  logic        pcw [3];
  logic        fl  [3];
  logic [15:0] hc  [3];
  logic [15:0] bc  [3];
  logic [2:0]  hc4;
  logic [2:0]  bc4;

  load_use_hazard_unit #(.STALL_CYCLES(1), .CNT_W(16)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ex_MemRead_i(mr), .ex_rd_i(rd),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_useRs2_i(use2), .branch_taken_i(br),
    .NoOp_o(nop[0]), .Stall_o(stl[0]), .PCWrite_o(pcw[0]), .Flush_o(fl[0]),
    .hazard_cnt_o(hc[0]), .bubble_cnt_o(bc[0]));

  load_use_hazard_unit #(.STALL_CYCLES(3), .CNT_W(16)) u3 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ex_MemRead_i(mr), .ex_rd_i(rd),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_useRs2_i(use2), .branch_taken_i(br),
    .NoOp_o(nop[1]), .Stall_o(stl[1]), .PCWrite_o(pcw[1]), .Flush_o(fl[1]),
    .hazard_cnt_o(hc[1]), .bubble_cnt_o(bc[1]));

  load_use_hazard_unit #(.STALL_CYCLES(4), .CNT_W(3)) u4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ex_MemRead_i(mr), .ex_rd_i(rd),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_useRs2_i(use2), .branch_taken_i(br),
    .NoOp_o(nop[2]), .Stall_o(stl[2]), .PCWrite_o(pcw[2]), .Flush_o(fl[2]),
    .hazard_cnt_o(hc4), .bubble_cnt_o(bc4));

  assign hc[2] = {13'd0, hc4};
  assign bc[2] = {13'd0, bc4};

  // Model: remaining bubbles still owed per instance, plus saturating event counts.
  int sc   [3] = '{1, 3, 4};
  int maxc [3] = '{65535, 65535, 7};
  int rem  [3] = '{0, 0, 0};
  int hcnt [3] = '{0, 0, 0};
  int bcnt [3] = '{0, 0, 0};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_hazard();
    if (!mr || rd == 5'd0) return 1'b0;
    if (rd == rs1) return 1'b1;
    return use2 && (rd == rs2);
  endfunction

  // Expected {NoOp, Stall, PCWrite, Flush} for instance i under the current inputs.
  function automatic logic [3:0] exp_out(input int i);
    if (rst)                return 4'b0010;
    if (!start)             return 4'b0000;
    if (rem[i] > 0)         return 4'b1100;
    if (is_hazard())        return 4'b1100;
    return {2'b00, 1'b1, br};
  endfunction

  function automatic int sat_inc(input int v, input int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  task automatic step();
    logic [3:0] e;
    #1;
    for (int i = 0; i < 3; i++) begin
      e = exp_out(i);
      check($sformatf("u%0d_noop", i), 32'(nop[i]), 32'(e[3]));
      check($sformatf("u%0d_stall", i), 32'(stl[i]), 32'(e[2]));
      check($sformatf("u%0d_pcwrite", i), 32'(pcw[i]), 32'(e[1]));
      check($sformatf("u%0d_flush", i), 32'(fl[i]), 32'(e[0]));
      check($sformatf("u%0d_hazard_cnt", i), 32'(hc[i]), STATS ? 32'(hcnt[i]) : 32'd0);
      check($sformatf("u%0d_bubble_cnt", i), 32'(bc[i]), STATS ? 32'(bcnt[i]) : 32'd0);
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        rem[i] = 0; hcnt[i] = 0; bcnt[i] = 0;
      end else if (start) begin
        if (rem[i] > 0) begin
          rem[i]--;
          bcnt[i] = sat_inc(bcnt[i], maxc[i]);
        end else if (is_hazard()) begin
          rem[i]  = sc[i] - 1;
          hcnt[i] = sat_inc(hcnt[i], maxc[i]);
          bcnt[i] = sat_inc(bcnt[i], maxc[i]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; start = 1'b1; mr = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; use2 = 1'b0; br = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);

    // Reset held two cycles, then released.
    do_reset();
    rst = 1'b1;
    step();
    idle_inputs();
    #1;
    check("rst_noop", 32'(nop[0]), 32'd0);
    check("rst_pcwrite", 32'(pcw[0]), 32'd1);
    check("rst_hcnt", 32'(hc[0]), 32'd0);
    step();

    // Single-bubble hazard on rs1.
    mr = 1'b1; rd = 5'd5; rs1 = 5'd5;
    #1;
    check("t2_noop", 32'(nop[0]), 32'd1);
    check("t2_pcwrite", 32'(pcw[0]), 32'd0);
    step();
    mr = 1'b0;
    #1;
    check("t2_after_pcwrite", 32'(pcw[0]), 32'd1);
    check("t2_hcnt", 32'(hc[0]), STATS ? 32'd1 : 32'd0);
    check("t2_bcnt", 32'(bc[0]), STATS ? 32'd1 : 32'd0);
    step();

    // Three-bubble hazard on rs2.
    do_reset();
    mr = 1'b1; rd = 5'd7; use2 = 1'b1; rs2 = 5'd7; rs1 = 5'd3;
    #1;
    check("t3_noop0", 32'(nop[1]), 32'd1);
    step();
    mr = 1'b0;
    #1;
    check("t3_noop1", 32'(nop[1]), 32'd1);
    step();
    #1;
    check("t3_noop2", 32'(nop[1]), 32'd1);
    step();
    #1;
    check("t3_done_noop", 32'(nop[1]), 32'd0);
    check("t3_done_pcwrite", 32'(pcw[1]), 32'd1);
    check("t3_bcnt", 32'(bc[1]), STATS ? 32'd3 : 32'd0);
    step();

    // Non-hazards: rd==0, and rs2 match without rs2 use.
    do_reset();
    mr = 1'b1; rd = 5'd0; rs1 = 5'd0;
    #1;
    check("t4_x0_pcwrite", 32'(pcw[2]), 32'd1);
    step();
    rd = 5'd9; rs2 = 5'd9; use2 = 1'b0; rs1 = 5'd1;
    #1;
    check("t4_nors2_noop", 32'(nop[2]), 32'd0);
    step();

    // Hazard beats branch; plain taken branch flushes.
    mr = 1'b1; rd = 5'd5; rs1 = 5'd5; br = 1'b1;
    #1;
    check("t5_flush_hz", 32'(fl[0]), 32'd0);
    check("t5_noop_hz", 32'(nop[0]), 32'd1);
    step();
    mr = 1'b0;
    #1;
    check("t5_flush", 32'(fl[0]), 32'd1);
    step();
    br = 1'b0;
    #1;
    check("t5_flush_off", 32'(fl[0]), 32'd0);
    step();

    // Reset mid-stall, then freeze mid-stall.
    do_reset();
    mr = 1'b1; rd = 5'd4; rs1 = 5'd4;
    step();
    mr = 1'b0; rst = 1'b1;
    #1;
    check("t6_rst_noop", 32'(nop[2]), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("t6_after_rst_noop", 32'(nop[2]), 32'd0);
    check("t6_after_rst_pcw", 32'(pcw[2]), 32'd1);
    step();
    mr = 1'b1;
    step();
    mr = 1'b0;
    step();
    start = 1'b0;
    #1;
    check("t6_frozen_noop", 32'(nop[2]), 32'd0);
    check("t6_frozen_pcw", 32'(pcw[2]), 32'd0);
    step();
    step();
    start = 1'b1;
    #1;
    check("t6_resume_noop", 32'(nop[2]), 32'd1);
    step();
    #1;
    check("t6_last_noop", 32'(nop[2]), 32'd1);
    step();
    #1;
    check("t6_end_noop", 32'(nop[2]), 32'd0);
    step();

    // Randomized traffic; small register range makes hazards frequent.
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 63) == 0);
      start = ($urandom_range(0, 9) != 0);
      mr    = $urandom_range(0, 1);
      rd    = 5'($urandom_range(0, 3));
      rs1   = 5'($urandom_range(0, 3));
      rs2   = 5'($urandom_range(0, 3));
      use2  = $urandom_range(0, 1);
      br    = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
